// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator and its consumers.
// The result code bit order matches the {err, lt, gt, eq} output grouping.
package serial_mag_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] RES_NONE = 4'b0000;
    localparam logic [3:0] RES_EQ   = 4'b0001;
    localparam logic [3:0] RES_GT   = 4'b0010;
    localparam logic [3:0] RES_LT   = 4'b0100;
    localparam logic [3:0] RES_ERR  = 4'b1000;

endpackage

// File: rtl/serial_shift_pair.sv
// Two WIDTH-bit load/shift-left registers; the MSB taps feed the external 1-bit cell.
module serial_shift_pair #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] a_load,
    input  logic [WIDTH-1:0] b_load,
    output logic             a_msb,
    output logic             b_msb
);

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
        end else if (clear) begin
            sa <= '0;
            sb <= '0;
        end else if (load) begin
            sa <= a_load;
            sb <= b_load;
        end else if (shift) begin
            sa <= {sa[WIDTH-2:0], 1'b0};
            sb <= {sb[WIDTH-2:0], 1'b0};
        end
    end

    assign a_msb = sa[WIDTH-1];
    assign b_msb = sb[WIDTH-1];

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator controller: streams operands MSB-first into an
// external 1-bit cell and stops on the first differing bit.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_eg,
    input  logic             cmp_agb,
    input  logic             cmp_alb,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             err,
    output logic [CW-1:0]    bits_used
);

    state_t          state;
    state_t          state_next;
    logic            load;
    logic            shift;
    logic            clear;
    logic            finish;
    logic [3:0]      res_next;
    logic [CW-1:0]   count;

    // cmp_a/cmp_b come straight from the shift register MSB flops.
    serial_shift_pair #(
        .WIDTH (WIDTH)
    ) u_shift_pair (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .shift  (shift),
        .clear  (clear),
        .a_load (a_in),
        .b_load (b_in),
        .a_msb  (cmp_a),
        .b_msb  (cmp_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        finish     = 1'b0;
        res_next   = RES_NONE;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                case ({cmp_eg, cmp_agb, cmp_alb})
                    3'b100: begin
                        if (count == CW'(WIDTH)) begin
                            finish     = 1'b1;
                            res_next   = RES_EQ;
                            state_next = DONE;
                        end else begin
                            shift = 1'b1;
                        end
                    end
                    3'b010: begin
                        finish     = 1'b1;
                        res_next   = RES_GT;
                        state_next = DONE;
                    end
                    3'b001: begin
                        finish     = 1'b1;
                        res_next   = RES_LT;
                        state_next = DONE;
                    end
                    default: begin
                        finish     = 1'b1;
                        res_next   = RES_ERR;
                        state_next = DONE;
                    end
                endcase
            end
            DONE: begin
                clear      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            err       <= 1'b0;
            bits_used <= '0;
        end else if (load) begin
            count <= CW'(1);
            {err, lt, gt, eq} <= RES_NONE;
        end else if (shift) begin
            count <= count + CW'(1);
        end else if (finish) begin
            {err, lt, gt, eq} <= res_next;
            bits_used         <= count;
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench: external 1-bit cell plus an arithmetic reference model.
module tb_serial_mag_comparator;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cmp_a;
    logic             cmp_b;
    logic             cmp_eg;
    logic             cmp_agb;
    logic             cmp_alb;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             err;
    logic [CW-1:0]    bits_used;

    logic             force_en;
    logic [2:0]       force_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External 1-bit comparator cell, with an override for fault injection.
    always_comb begin
        if (force_en) begin
            {cmp_eg, cmp_agb, cmp_alb} = force_val;
        end else begin
            cmp_eg  = (cmp_a == cmp_b);
            cmp_agb = cmp_a & ~cmp_b;
            cmp_alb = ~cmp_a & cmp_b;
        end
    end

    serial_mag_comparator #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_eg    (cmp_eg),
        .cmp_agb   (cmp_agb),
        .cmp_alb   (cmp_alb),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .err       (err),
        .bits_used (bits_used)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 1-based position from MSB of the first differing bit, WIDTH when equal.
    function automatic int ref_k(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return WIDTH - i;
        end
        return WIDTH;
    endfunction

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered #1 after the accepting edge; runs until done and checks the result.
    task automatic finish_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic exp_err, input int exp_k, input logic poke);
        int               lat   = 1;
        int               nbusy = 0;
        logic [WIDTH-1:0] seq_a = '0;
        logic [WIDTH-1:0] seq_b = '0;
        logic [3:0]       exp_res;
        while (!done && lat <= 4 * WIDTH) begin
            if (busy) begin
                nbusy++;
                if (nbusy <= WIDTH) begin
                    seq_a[WIDTH-nbusy] = cmp_a;
                    seq_b[WIDTH-nbusy] = cmp_b;
                end
            end
            if (poke && lat == 1) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = ~b;
            end else if (poke && lat == 2) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (exp_err) exp_res = 4'b1000;
        else         exp_res = {1'b0, a < b, a > b, a == b};
        check({tag, "_latency"}, lat, exp_k + 1);
        check({tag, "_busy_cycles"}, nbusy, exp_k);
        check({tag, "_result"}, {err, lt, gt, eq}, exp_res);
        check({tag, "_bits_used"}, bits_used, exp_k);
        check({tag, "_seq_a"}, seq_a >> (WIDTH - exp_k), a >> (WIDTH - exp_k));
        check({tag, "_seq_b"}, seq_b >> (WIDTH - exp_k), b >> (WIDTH - exp_k));
        @(posedge clk);
        #1;
        check({tag, "_after"}, {done, busy, cmp_a, cmp_b}, 4'b0000);
        check({tag, "_held"}, {err, lt, gt, eq}, exp_res);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        force_en  = 1'b0;
        force_val = 3'b000;
        #12;
        check("reset_outputs", {cmp_a, cmp_b, busy, done, eq, gt, lt, err, bits_used}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(4'b1010, 4'b0110);
        finish_cmp("msb_gt", 4'b1010, 4'b0110, 1'b0, 1, 1'b0);
        launch(4'b1011, 4'b1101);
        finish_cmp("bit2_lt", 4'b1011, 4'b1101, 1'b0, 2, 1'b0);
        launch(4'b1001, 4'b1001);
        finish_cmp("equal", 4'b1001, 4'b1001, 1'b0, 4, 1'b0);

        force_en  = 1'b1;
        force_val = 3'b011;
        launch(4'b1100, 4'b1100);
        finish_cmp("err_011", 4'b1100, 4'b1100, 1'b1, 1, 1'b0);
        force_val = 3'b000;
        launch(4'b0101, 4'b0011);
        finish_cmp("err_000", 4'b0101, 4'b0011, 1'b1, 1, 1'b0);
        force_en = 1'b0;

        launch(4'b1001, 4'b1001);
        finish_cmp("start_in_shift", 4'b1001, 4'b1001, 1'b0, 4, 1'b1);

        // Held start: first compare, one IDLE cycle, then an automatic second accept.
        @(negedge clk);
        a_in  = 4'b0111;
        b_in  = 4'b0101;
        start = 1'b1;
        @(posedge clk);
        #1;
        finish_cmp("held_first", 4'b0111, 4'b0101, 1'b0, 3, 1'b0);
        a_in = 4'b0010;
        b_in = 4'b1000;
        @(posedge clk);
        #1;
        check("held_second_accept", {busy, err, lt, gt, eq}, 5'b10000);
        start = 1'b0;
        finish_cmp("held_second", 4'b0010, 4'b1000, 1'b0, 1, 1'b0);

        launch(4'b1111, 4'b1110);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_shift", {cmp_a, cmp_b, busy, done, eq, gt, lt, err, bits_used}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_no_done", {done, busy}, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(4'b1111, 4'b1110);
        finish_cmp("after_reset", 4'b1111, 4'b1110, 1'b0, 4, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            launch(ra, rb);
            finish_cmp("random", ra, rb, 1'b0, ref_k(ra, rb), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial WIDTH-bit magnitude comparator controller.
- Latches two operands on start and drives them MSB-first, one bit per clock, into an external 1-bit comparator cell.
- Consumes that cell's eg/agb/alb outputs, terminates on the first differing bit and registers a one-hot result with a done pulse.
- Sits between the clock/alarm compare logic (time vs. setpoint) and the 1-bit comparator cell.

Parameters:
- WIDTH, 4, operand width in bits (>=2)
- CW, $clog2(WIDTH+1), width of the bit counter / bits_used (localparam, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request compare; sampled only in IDLE
- a_in  in  WIDTH  operand A, captured on accepted start
- b_in  in  WIDTH  operand B, captured on accepted start
- cmp_a  out  1  current A bit to 1-bit cell (registered)
- cmp_b  out  1  current B bit to 1-bit cell (registered)
- cmp_eg  in  1  cell result a==b (combinational return)
- cmp_agb  in  1  cell result a>b
- cmp_alb  in  1  cell result a<b
- busy  out  1  high in SHIFT
- done  out  1  one-cycle pulse when result is valid
- eq  out  1  A==B, held until next accepted start
- gt  out  1  A>B, held
- lt  out  1  A<B, held
- err  out  1  cell returned a non-one-hot triple; held
- bits_used  out  CW  number of bit positions examined, held

Behaviour:
- Async reset (rst_n=0) forces state IDLE and clears the shift registers and counter. All outputs reset to 0: cmp_a, cmp_b, busy, done, eq, gt, lt, err, bits_used.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches a_in/b_in into shift registers sa/sb and clears eq/gt/lt/err.
  - Loads cmp_a=a_in[WIDTH-1], cmp_b=b_in[WIDTH-1] and counter=1, then goes to SHIFT.
  - start=0 holds state.
- SHIFT (busy=1): each rising edge samples {cmp_eg, cmp_agb, cmp_alb}.
  - Exactly one bit set and cmp_eg=1 with counter<WIDTH: shift sa/sb left, present the next bit on cmp_a/cmp_b, counter+1, stay in SHIFT.
  - cmp_eg=1 with counter==WIDTH: eq<=1, bits_used<=WIDTH, go to DONE.
  - cmp_agb=1: gt<=1, bits_used<=counter, go to DONE (early termination).
  - cmp_alb=1: lt<=1, bits_used<=counter, go to DONE.
  - Triple not one-hot (000, or two or more bits set): err<=1, eq/gt/lt stay 0, bits_used<=counter, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, cmp_a/cmp_b<=0, then return to IDLE.
  - start is ignored in DONE.
- Latency: accepted start at edge 0; k SHIFT edges, where k = 1-based position from MSB of the first differing bit, or WIDTH if equal; done high the cycle after the k-th SHIFT edge. Total start-to-done = k+1 edges, max WIDTH+1.
- start during SHIFT or DONE: ignored. Operands are not re-captured, and no queueing.
- start held high continuously: a new compare is accepted on each IDLE visit (back-to-back with one IDLE cycle between).
- Result outputs: exactly one of eq/gt/lt/err is high after done, until the next accepted start clears them.
- Reset mid-SHIFT: immediate abort to IDLE. No done pulse; results cleared.
- Counter never exceeds WIDTH; no wrap.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a one-hot result code constant set (RES_EQ, RES_GT, RES_LT, RES_ERR) for use by clock/alarm consumers.
- Optional sub-module: serial_shift_pair (two WIDTH-bit load/shift-left registers with MSB taps).
- The 1-bit comparator cell stays external and is instantiated in the bench/top.

Test Plan:
- WIDTH=4, a=4'b1010, b=4'b0110, real 1-bit cell attached -> differs at MSB: gt=1, bits_used=1, done 2 edges after start.
- a=4'b1011, b=4'b1101 -> MSB equal, bit2 differs: lt=1, bits_used=2, busy high 2 cycles, done at edge 3.
- a=b=4'b1001 -> eq=1, gt=lt=err=0, bits_used=4, done at edge 5; cmp_a/cmp_b sequence 1,0,0,1.
- Forced cell returning 3'b011 on first SHIFT edge -> err=1, eq/gt/lt=0, bits_used=1, done pulses.
- start pulsed again during SHIFT with different operands -> ignored; result matches first operands. start held high -> second compare begins after one IDLE cycle.
- rst_n low mid-SHIFT (a=4'b1111, b=4'b1110, after edge 2) -> all outputs 0, no done. New start after release -> gt=1, bits_used=4.
